cp0_reg: RTL and testbench

CP0_REG -- requirements
Module: cp0_reg

---
 rtl/cp0_reg_if.sv | 36 +++
 rtl/cp0_reg.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_cp0_reg.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_reg_if
//  Description : Software access bus for the CP0 register file. It carries
//                the MTC0 write port (we_i / waddr_i / data_i) and the MFC0
//                read port (raddr_i / data_o).
//  Modports    : master - pipeline side; drives the write and read address
//                         fields and receives the read data.
//                slave  - cp0_reg side; receives the write and read address
//                         fields and returns the read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface cp0_reg_if;
    logic        we_i;     // MTC0 write enable
    logic [4:0]  waddr_i;  // CP0 register number written
    logic [31:0] data_i;   // MTC0 write data
    logic [4:0]  raddr_i;  // CP0 register number read
    logic [31:0] data_o;   // MFC0 read data (combinational)

    modport master (
        output we_i,
        output waddr_i,
        output data_i,
        output raddr_i,
        input  data_o
    );

    modport slave (
        input  we_i,
        input  waddr_i,
        input  data_i,
        input  raddr_i,
        output data_o
    );
endinterface
`default_nettype wire

// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_reg
//  Description : MIPS coprocessor-0 register file. Implements BadVAddr(8),
//                Count(9), Compare(11), Status(12), Cause(13) and EPC(14),
//                MTC0 writes with per-field write masks, combinational MFC0
//                reads, precise exception entry and ERET.
//  Ports       : clk                 - sole clock, rising edge
//                rst                 - asynchronous active-high reset
//                bus                 - cp0_reg_if.slave (MTC0 / MFC0 port)
//                int_i[5:0]          - external hardware interrupt lines
//                excepttype_i[31:0]  - exception code from the M stage
//                current_inst_addr_i - PC of the excepting instruction
//                is_in_delayslot_i   - excepting instruction in delay slot
//                bad_addr_i          - faulting address (address errors)
//                badvaddr_o, count_o, compare_o, status_o, cause_o, epc_o
//                                    - register contents
//                timer_int_o         - timer interrupt pending
//  Options     : CP0_TIMER_INT_EN - when defined, Count increments every
//                second cycle and a Count==Compare match raises the timer
//                interrupt. When undefined, Count is a plain register and
//                the timer interrupt is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_reg (
    input  wire logic        clk,
    input  wire logic        rst,
    cp0_reg_if.slave         bus,
    input  wire logic [5:0]  int_i,
    input  wire logic [31:0] excepttype_i,
    input  wire logic [31:0] current_inst_addr_i,
    input  wire logic        is_in_delayslot_i,
    input  wire logic [31:0] bad_addr_i,
    output logic      [31:0] badvaddr_o,
    output logic      [31:0] count_o,
    output logic      [31:0] compare_o,
    output logic      [31:0] status_o,
    output logic      [31:0] cause_o,
    output logic      [31:0] epc_o,
    output logic             timer_int_o
);

    // ------------------------------------------------------------------
    // Register numbers
    // ------------------------------------------------------------------
    localparam logic [4:0] C_REG_BADVADDR = 5'd8;
    localparam logic [4:0] C_REG_COUNT    = 5'd9;
    localparam logic [4:0] C_REG_COMPARE  = 5'd11;
    localparam logic [4:0] C_REG_STATUS   = 5'd12;
    localparam logic [4:0] C_REG_CAUSE    = 5'd13;
    localparam logic [4:0] C_REG_EPC      = 5'd14;

    // Exception type codes presented by the exception unit
    localparam logic [31:0] C_EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] C_EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] C_EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] C_EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] C_EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] C_EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] C_EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] C_EXC_ERET = 32'h0000_000e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_epc;

    // Only the writable Status fields are stored; BEV and the zero
    // fields are constants stitched in on the output.
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;

    // Cause fields. TI is the timer interrupt flag itself.
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exc;

    logic        w_timer_int;

    // ------------------------------------------------------------------
    // MTC0 write decode
    // ------------------------------------------------------------------
    logic w_wr_badvaddr;
    logic w_wr_count;
    logic w_wr_compare;
    logic w_wr_status;
    logic w_wr_cause;
    logic w_wr_epc;

    assign w_wr_badvaddr = bus.we_i && (bus.waddr_i == C_REG_BADVADDR);
    assign w_wr_count    = bus.we_i && (bus.waddr_i == C_REG_COUNT);
    assign w_wr_compare  = bus.we_i && (bus.waddr_i == C_REG_COMPARE);
    assign w_wr_status   = bus.we_i && (bus.waddr_i == C_REG_STATUS);
    assign w_wr_cause    = bus.we_i && (bus.waddr_i == C_REG_CAUSE);
    assign w_wr_epc      = bus.we_i && (bus.waddr_i == C_REG_EPC);

    // ------------------------------------------------------------------
    // Exception decode. Interrupt (type 0x1) maps to ExcCode 0; the other
    // accepted types carry their ExcCode in the low bits. Any value not
    // listed here (including 0) is ignored.
    // ------------------------------------------------------------------
    logic       w_exc_valid;
    logic [4:0] w_exc_code;
    logic       w_exc_addr;
    logic       w_eret;

    always_comb begin
        w_exc_valid = 1'b0;
        w_exc_code  = 5'd0;
        case (excepttype_i)
            C_EXC_INT:  begin w_exc_valid = 1'b1; w_exc_code = 5'h00; end
            C_EXC_ADEL: begin w_exc_valid = 1'b1; w_exc_code = 5'h04; end
            C_EXC_ADES: begin w_exc_valid = 1'b1; w_exc_code = 5'h05; end
            C_EXC_SYS:  begin w_exc_valid = 1'b1; w_exc_code = 5'h08; end
            C_EXC_BP:   begin w_exc_valid = 1'b1; w_exc_code = 5'h09; end
            C_EXC_RI:   begin w_exc_valid = 1'b1; w_exc_code = 5'h0a; end
            C_EXC_OV:   begin w_exc_valid = 1'b1; w_exc_code = 5'h0c; end
            default:    begin w_exc_valid = 1'b0; w_exc_code = 5'h00; end
        endcase
    end

    assign w_exc_addr = (excepttype_i == C_EXC_ADEL) || (excepttype_i == C_EXC_ADES);
    assign w_eret     = (excepttype_i == C_EXC_ERET);

    // EPC/BD are only captured on the first exception; nested ones taken
    // while EXL is already set must not overwrite the original return PC.
    logic        w_exc_capture;
    logic [31:0] w_exc_epc;

    assign w_exc_capture = w_exc_valid && !r_status_exl;
    assign w_exc_epc     = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                             : current_inst_addr_i;

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status_im  <= 8'd0;
            r_status_exl <= 1'b0;
            r_status_ie  <= 1'b0;
        end else begin
            if (w_wr_status) begin
                r_status_im  <= bus.data_i[15:8];
                r_status_exl <= bus.data_i[1];
                r_status_ie  <= bus.data_i[0];
            end
            // Exception entry / return override a same-cycle MTC0 on EXL.
            if (w_exc_valid) begin
                r_status_exl <= 1'b1;
            end else if (w_eret) begin
                r_status_exl <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cause
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause_bd    <= 1'b0;
            r_cause_ip_hw <= 6'd0;
            r_cause_ip_sw <= 2'd0;
            r_cause_exc   <= 5'd0;
        end else begin
            // IP7 doubles as the timer interrupt line.
            r_cause_ip_hw <= {int_i[5] | w_timer_int, int_i[4:0]};
            if (w_wr_cause) begin
                r_cause_ip_sw <= bus.data_i[9:8];
            end
            if (w_exc_valid) begin
                r_cause_exc <= w_exc_code;
            end
            if (w_exc_capture) begin
                r_cause_bd <= is_in_delayslot_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // EPC
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc <= 32'd0;
        end else if (w_exc_capture) begin
            r_epc <= w_exc_epc;
        end else if (w_wr_epc) begin
            r_epc <= bus.data_i;
        end
    end

    // ------------------------------------------------------------------
    // BadVAddr
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_badvaddr <= 32'd0;
        end else if (w_exc_valid && w_exc_addr) begin
            r_badvaddr <= bad_addr_i;
        end else if (w_wr_badvaddr) begin
            r_badvaddr <= bus.data_i;
        end
    end

    // ------------------------------------------------------------------
    // Compare
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_compare <= 32'd0;
        end else if (w_wr_compare) begin
            r_compare <= bus.data_i;
        end
    end

    // ------------------------------------------------------------------
    // Count and timer interrupt
    // ------------------------------------------------------------------
`ifdef CP0_TIMER_INT_EN
    logic r_tick;
    logic r_timer_int;

    // Count advances on every second clock; a software load of Count
    // restarts that phase so the first increment is two cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 32'd0;
            r_tick  <= 1'b0;
        end else if (w_wr_count) begin
            r_count <= bus.data_i;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Sticky until software rewrites Compare. A Compare of zero never
    // matches, so a cleared Compare leaves the timer disarmed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer_int <= 1'b0;
        end else if (w_wr_compare) begin
            r_timer_int <= 1'b0;
        end else if ((r_compare != 32'd0) && (r_count == r_compare)) begin
            r_timer_int <= 1'b1;
        end
    end

    assign w_timer_int = r_timer_int;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 32'd0;
        end else if (w_wr_count) begin
            r_count <= bus.data_i;
        end
    end

    assign w_timer_int = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign badvaddr_o  = r_badvaddr;
    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign epc_o       = r_epc;
    assign timer_int_o = w_timer_int;

    // BEV (bit 22) reads as a constant 1.
    assign status_o = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};

    assign cause_o  = {r_cause_bd, w_timer_int, 14'd0, r_cause_ip_hw, r_cause_ip_sw,
                       1'b0, r_cause_exc, 2'd0};

    // MFC0 read port: reflects current register contents only.
    always_comb begin
        case (bus.raddr_i)
            C_REG_BADVADDR: bus.data_o = badvaddr_o;
            C_REG_COUNT:    bus.data_o = count_o;
            C_REG_COMPARE:  bus.data_o = compare_o;
            C_REG_STATUS:   bus.data_o = status_o;
            C_REG_CAUSE:    bus.data_o = cause_o;
            C_REG_EPC:      bus.data_o = epc_o;
            default:        bus.data_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_reg
//  Description : Self-checking bench for cp0_reg. Directed scenarios followed
//                by randomized MTC0 / exception / interrupt traffic, all
//                checked against a register-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] badvaddr_o, count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o;

    cp0_reg_if bus ();

    cp0_reg dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus.slave),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .bad_addr_i          (bad_addr_i),
        .badvaddr_o          (badvaddr_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .timer_int_o         (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register values
    logic [31:0] m_bad, m_count, m_cmp, m_status, m_cause, m_epc;
    logic        m_timer, m_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_bad = 0; m_count = 0; m_cmp = 0; m_status = 32'h0040_0000;
        m_cause = 0; m_epc = 0; m_timer = 0; m_tick = 0;
    endtask

    // Next architectural state from the current state and the inputs
    // present at the clock edge.
    task automatic model_edge();
        logic [31:0] n_bad, n_count, n_cmp, n_status, n_cause, n_epc;
        logic        n_timer;
        int          code;
        n_bad = m_bad; n_count = m_count; n_cmp = m_cmp; n_status = m_status;
        n_cause = m_cause; n_epc = m_epc; n_timer = m_timer;
        if (bus.we_i) begin
            case (bus.waddr_i)
                5'd8:  n_bad = bus.data_i;
                5'd9:  n_count = bus.data_i;
                5'd11: n_cmp = bus.data_i;
                5'd12: n_status = 32'h0040_0000 | (bus.data_i & 32'h0000_FF03);
                5'd13: n_cause = (m_cause & ~32'h300) | (bus.data_i & 32'h300);
                5'd14: n_epc = bus.data_i;
                default: ;
            endcase
        end
        case (excepttype_i)
            32'h1: code = 0;   32'h4: code = 4;   32'h5: code = 5;
            32'h8: code = 8;   32'h9: code = 9;   32'ha: code = 10;
            32'hc: code = 12;  default: code = -1;
        endcase
        if (code >= 0) begin
            n_cause[6:2] = code[4:0];
            if (!m_status[1]) begin
                n_epc = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                n_cause[31] = is_in_delayslot_i;
            end
            n_status[1] = 1'b1;
            if (excepttype_i == 32'h4 || excepttype_i == 32'h5) n_bad = bad_addr_i;
        end else if (excepttype_i == 32'he) begin
            n_status[1] = 1'b0;
        end
        n_cause[15:10] = {int_i[5] | m_timer, int_i[4:0]};
`ifdef CP0_TIMER_INT_EN
        if (bus.we_i && bus.waddr_i == 5'd9) begin
            m_tick = 1'b0;
        end else begin
            if (m_tick) n_count = m_count + 32'd1;
            m_tick = !m_tick;
        end
        if (bus.we_i && bus.waddr_i == 5'd11) n_timer = 1'b0;
        else if (m_cmp != 0 && m_count == m_cmp) n_timer = 1'b1;
`endif
        n_cause[30] = n_timer;
        m_bad = n_bad; m_count = n_count; m_cmp = n_cmp; m_status = n_status;
        m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
    endtask

    task automatic check_all(input string where);
        chk({where, ":status"},   status_o,   m_status);
        chk({where, ":cause"},    cause_o,    m_cause);
        chk({where, ":epc"},      epc_o,      m_epc);
        chk({where, ":badvaddr"}, badvaddr_o, m_bad);
        chk({where, ":count"},    count_o,    m_count);
        chk({where, ":compare"},  compare_o,  m_cmp);
        chk({where, ":timer"},    {31'd0, timer_int_o}, {31'd0, m_timer});
        chk({where, ":data_o"},   bus.data_o, m_read(bus.raddr_i));
    endtask

    // One clock with the currently driven inputs, then check.
    task automatic cycle(input string where);
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all(where);
    endtask

    task automatic idle();
        bus.we_i = 0; bus.waddr_i = 0; bus.data_i = 0;
        excepttype_i = 0; int_i = 0; is_in_delayslot_i = 0;
        current_inst_addr_i = 0; bad_addr_i = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1; bus.waddr_i = a; bus.data_i = d;
        cycle("mtc0");
        bus.we_i = 0;
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                       input logic [31:0] ba);
        excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = ba;
        cycle("exc");
        excepttype_i = 0;
    endtask

    logic [31:0] exc_tab [12];
    logic [4:0]  reg_tab [7];

    initial begin
        exc_tab = '{32'h0, 32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc,
                    32'he, 32'h2, 32'h0, 32'h0};
        reg_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd10};
        rst = 0;
        idle();
        bus.raddr_i = 5'd12;

        // Asynchronous reset, observed before any clock edge
        #2 rst = 1;
        #1;
        model_reset();
        check_all("reset");
        chk("reset_status_lit", status_o, 32'h0040_0000);
        @(negedge clk);
        rst = 0;

        // Status / Cause write masks
        mtc0(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status_o, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("cause_mask", cause_o, 32'h0000_0300);
        mtc0(5'd12, 32'h0000_0000);

        // Syscall outside a delay slot, then ERET
        exc(32'h8, 32'hBFC0_0100, 1'b0, 32'h0);
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_exccode", {27'd0, cause_o[6:2]}, 32'h8);
        chk("sys_bd", {31'd0, cause_o[31]}, 32'd0);
        chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
        exc(32'he, 32'h0, 1'b0, 32'h0);
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
        chk("eret_epc", epc_o, 32'hBFC0_0100);

        // Address error in a delay slot, then a nested overflow
        exc(32'h4, 32'hBFC0_0204, 1'b1, 32'h0000_0003);
        chk("adel_epc", epc_o, 32'hBFC0_0200);
        chk("adel_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("adel_badvaddr", badvaddr_o, 32'h0000_0003);
        exc(32'hc, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF);
        chk("nested_epc", epc_o, 32'hBFC0_0200);
        chk("nested_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("nested_exccode", {27'd0, cause_o[6:2]}, 32'hc);
        chk("nested_badvaddr", badvaddr_o, 32'h0000_0003);
        exc(32'he, 32'h0, 1'b0, 32'h0);

        // Interrupt line latency and exception beating MTC0 on EPC
        int_i = 6'b000001;
        bus.we_i = 1; bus.waddr_i = 5'd14; bus.data_i = 32'hDEAD_BEEF;
        excepttype_i = 32'h1; current_inst_addr_i = 32'h8000_0000;
        cycle("int_epc");
        idle();
        chk("int_ip2", {31'd0, cause_o[10]}, 32'd1);
        chk("int_epc_lit", epc_o, 32'h8000_0000);
        exc(32'he, 32'h0, 1'b0, 32'h0);

        // EPC subtraction wraps
        exc(32'h9, 32'h0000_0000, 1'b1, 32'h0);
        chk("epc_wrap", epc_o, 32'hFFFF_FFFC);
        exc(32'he, 32'h0, 1'b0, 32'h0);

`ifdef CP0_TIMER_INT_EN
        // Timer: Compare=5, Count=0, expect interrupt within a bounded wait
        begin
            int n;
            mtc0(5'd11, 32'd5);
            mtc0(5'd9, 32'd0);
            n = 0;
            while (!timer_int_o && n < 40) begin
                cycle("timer_wait");
                n++;
            end
            chk("timer_fired", {31'd0, timer_int_o}, 32'd1);
            chk("timer_latency", n, 11);
            cycle("timer_ip7");
            chk("timer_ti", {31'd0, cause_o[30]}, 32'd1);
            chk("timer_ip7_lit", {31'd0, cause_o[15]}, 32'd1);
            mtc0(5'd11, 32'd0);
            chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
        end
`else
        // Without the timer, Count holds its written value
        mtc0(5'd9, 32'hFFFF_FFFF);
        repeat (4) cycle("count_hold");
        chk("count_static", count_o, 32'hFFFF_FFFF);
        chk("no_timer", {31'd0, timer_int_o}, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.we_i     = ($urandom_range(0, 2) == 0);
            bus.waddr_i  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : reg_tab[$urandom_range(0, 6)];
            bus.data_i   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
            bus.raddr_i  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : reg_tab[$urandom_range(0, 6)];
            excepttype_i = ($urandom_range(0, 15) == 0) ? $urandom : exc_tab[$urandom_range(0, 11)];
            int_i        = 6'($urandom);
            is_in_delayslot_i   = 1'($urandom);
            current_inst_addr_i = $urandom;
            bad_addr_i          = $urandom;
            cycle("rand");
        end

        // Reset asserted with an exception pending discards it
        idle();
        bus.raddr_i = 5'd14;
        excepttype_i = 32'h8; current_inst_addr_i = 32'hCAFE_0000;
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        check_all("rst_mid");
        cycle("rst_hold");
        @(negedge clk);
        rst = 0;
        cycle("post_rst");
        chk("post_rst_epc", epc_o, 32'hCAFE_0000);
        idle();
        cycle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
